// File: rtl/quad_phase_select_if.sv
// Phase-select request channel: requester drives sel/sel_valid, the selector
// answers with ready, a one-cycle done pulse and the committed phase.
interface quad_phase_select_if;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       sel_done;
    logic [1:0] cur_sel;

    modport master (
        output sel,
        output sel_valid,
        input  sel_ready,
        input  sel_done,
        input  cur_sel
    );

    modport slave (
        input  sel,
        input  sel_valid,
        output sel_ready,
        output sel_done,
        output cur_sel
    );
endinterface

// File: rtl/quad_phase_select.sv
// Quadrature lock monitor and glitch-free phase selector for the divide-by-4
// phases: verifies the C-9-3-6 rotation, then forwards one phase as clk_out.
//
// lock fsm    | meaning
// ------------+--------------------------------------------------------------
// LK_UNLOCKED | counting consecutive good samples toward LOCK_CYCLES
// LK_LOCKED   | rotation verified; any bad sample drops lock and bumps err_cnt
//
// select fsm  | meaning
// ------------+--------------------------------------------------------------
// SS_IDLE     | clk_out follows cur_sel; requests accepted while locked
// SS_DRAIN    | waiting for the current phase to go low before gating
// SS_ARM      | clk_out held low until the target phase is low, then commit
module quad_phase_select #(
    parameter int         LOCK_CYCLES = 8,
    parameter int         ERR_W       = 8,
    parameter logic [1:0] RESET_SEL   = 2'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ph0,
    input  logic               ph90,
    input  logic               ph180,
    input  logic               ph270,
    quad_phase_select_if.slave sel_if,
    output logic               clk_out,
    output logic               locked,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [0:0] LK_UNLOCKED = 1'b0;
    localparam logic [0:0] LK_LOCKED   = 1'b1;

    localparam logic [1:0] SS_IDLE  = 2'd0;
    localparam logic [1:0] SS_DRAIN = 2'd1;
    localparam logic [1:0] SS_ARM   = 2'd2;

    logic [3:0]       ph_q;
    logic [3:0]       ph_prev;
    logic [3:0]       ph_rot;
    logic             legal;
    logic             good;
    logic [0:0]       lk_state;
    logic [CNT_W-1:0] lock_cnt;

    logic [1:0]       ss_state;
    logic [1:0]       tgt;
    logic [1:0]       cur_sel;
    logic             gate;
    logic             sel_done;
    logic             sel_ready;
    logic             accept;
    logic             force_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q    <= 4'h0;
            ph_prev <= 4'h0;
        end else begin
            ph_q    <= {ph270, ph180, ph90, ph0};
            ph_prev <= ph_q;
        end
    end

    assign ph_rot = {ph_prev[2:0], ph_prev[3]};

    always_comb begin
        legal = (ph_q == 4'hC) || (ph_q == 4'h9) || (ph_q == 4'h3) || (ph_q == 4'h6);
        good  = legal && (ph_q == ph_rot);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_state <= LK_UNLOCKED;
            lock_cnt <= '0;
            err_cnt  <= '0;
        end else if (lk_state == LK_LOCKED) begin
            if (!good) begin
                lk_state <= LK_UNLOCKED;
                lock_cnt <= '0;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end else begin
            if (!good) begin
                lock_cnt <= '0;
            end else if (lock_cnt == LOCK_LAST) begin
                lk_state <= LK_LOCKED;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    assign locked       = (lk_state == LK_LOCKED);
    assign sel_ready    = (ss_state == SS_IDLE) && locked;
    assign accept       = sel_if.sel_valid && sel_ready;
    // Losing lock mid-switch abandons the glitch-free wait and commits at once.
    assign force_commit = !locked && (ss_state != SS_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_state <= SS_IDLE;
            tgt      <= RESET_SEL;
            cur_sel  <= RESET_SEL;
            gate     <= 1'b0;
            sel_done <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            sel_done <= 1'b0;
            // The forced-commit term keeps clk_out low on the commit cycle even from DRAIN.
            clk_out  <= (gate || force_commit) ? 1'b0 : ph_q[cur_sel];
            if (force_commit) begin
                cur_sel  <= tgt;
                sel_done <= 1'b1;
                gate     <= 1'b0;
                ss_state <= SS_IDLE;
            end else begin
                case (ss_state)
                    SS_IDLE: begin
                        if (accept) begin
                            tgt <= sel_if.sel;
                            if (sel_if.sel == cur_sel) begin
                                sel_done <= 1'b1;
                            end else begin
                                ss_state <= SS_DRAIN;
                            end
                        end
                    end
                    SS_DRAIN: begin
                        if (!ph_q[cur_sel]) begin
                            gate     <= 1'b1;
                            ss_state <= SS_ARM;
                        end
                    end
                    SS_ARM: begin
                        if (!ph_q[tgt]) begin
                            cur_sel  <= tgt;
                            sel_done <= 1'b1;
                            gate     <= 1'b0;
                            ss_state <= SS_IDLE;
                        end
                    end
                    default: begin
                        gate     <= 1'b0;
                        ss_state <= SS_IDLE;
                    end
                endcase
            end
        end
    end

    assign sel_if.sel_ready = sel_ready;
    assign sel_if.sel_done  = sel_done;
    assign sel_if.cur_sel   = cur_sel;

endmodule

// File: tb/tb_quad_phase_select.sv
// Bench for quad_phase_select: drives the legal rotation, injects bad samples
// and phase switches, and scoreboards clk_out against the 2-cycle delayed phase.
module tb_quad_phase_select;

    localparam int         LOCK_CYCLES = 8;
    localparam int         ERR_W       = 2;
    localparam logic [1:0] RESET_SEL   = 2'd0;
    localparam int         ERR_MAX     = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic             ph0, ph90, ph180, ph270;
    logic             clk_out;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    quad_phase_select_if sel_if ();

    quad_phase_select #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .ERR_W       (ERR_W),
        .RESET_SEL   (RESET_SEL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ph0     (ph0),
        .ph90    (ph90),
        .ph180   (ph180),
        .ph270   (ph270),
        .sel_if  (sel_if),
        .clk_out (clk_out),
        .locked  (locked),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [3:0] legal [4] = '{4'hC, 4'h9, 4'h3, 4'h6};
    logic [1:0] exp_q [$];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ncyc     = 0;
    int         idx      = 0;
    int         bad_edge = 0;
    int         exp_err  = 0;
    int         run      = 2;
    logic [1:0] exp_sel  = RESET_SEL;
    logic       sb_en    = 1'b1;
    logic       pw_en    = 1'b0;
    logic       acc_last = 1'b0;
    logic       prev_done = 1'b0;
    logic       last_co  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= ERR_MAX) ? ERR_MAX : v + 1;
    endfunction

    // One clock: drive a phase code, then sample #1 after the edge.
    task automatic cyc(input logic [3:0] code);
        logic [1:0] e;
        {ph270, ph180, ph90, ph0} = code;
        exp_q.push_back({sb_en, code[exp_sel]});
        acc_last = sel_if.sel_valid && sel_if.sel_ready;
        @(posedge clk);
        #1;
        ncyc++;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            if (e[1]) check("clk_out", clk_out, e[0]);
        end
        if (prev_done) check("done_1cyc", sel_if.sel_done, 1'b0);
        prev_done = sel_if.sel_done;
        if (pw_en) begin
            if (clk_out !== last_co) begin
                check("pulse_w", run >= 2, 1'b1);
                run = 1;
            end else begin
                run++;
            end
        end
        last_co = clk_out;
    endtask

    task automatic adv();
        cyc(legal[idx]);
        idx = (idx + 1) % 4;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sel_if.sel_valid = 1'b0;
        {ph270, ph180, ph90, ph0} = 4'h0;
        #1;
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_cur_sel", sel_if.cur_sel, RESET_SEL);
        check("rst_ready", sel_if.sel_ready, 1'b0);
        check("rst_done", sel_if.sel_done, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        idx       = 0;
        exp_sel   = RESET_SEL;
        exp_err   = 0;
        prev_done = 1'b0;
        sb_en     = 1'b1;
        pw_en     = 1'b0;
    endtask

    task automatic acquire();
        for (int n = 1; n <= 12; n++) begin
            adv();
            check("lock_acq", locked, n >= 10);
            check("acq_done", sel_if.sel_done, 1'b0);
        end
        check("acq_err", err_cnt, 0);
        pw_en   = 1'b1;
        run     = 2;
        last_co = clk_out;
    endtask

    task automatic wait_lock();
        int n;
        n = 0;
        while (!locked && n < 20) begin
            adv();
            n++;
            check("rdy_unlocked", sel_if.sel_ready, locked);
            check("err_hold", err_cnt, exp_err);
        end
        check("relock_time", ncyc - bad_edge, 10);
        pw_en   = 1'b1;
        run     = 2;
        last_co = clk_out;
    endtask

    task automatic do_switch(input logic [1:0] s);
        int   k;
        int   lows;
        logic same;
        same = (s == exp_sel);
        if (!same) sb_en = 1'b0;
        sel_if.sel       = s;
        sel_if.sel_valid = 1'b1;
        adv();
        check("sw_accept", acc_last, 1'b1);
        sel_if.sel_valid = 1'b0;
        k    = 0;
        lows = 0;
        while (!sel_if.sel_done && k < 10) begin
            adv();
            k++;
            if (clk_out == 1'b0) lows++;
        end
        check("sw_done", sel_if.sel_done, 1'b1);
        check("sw_cur", sel_if.cur_sel, s);
        if (same) begin
            check("same_lat", k, 0);
        end else begin
            check("sw_time", (k >= 2) && (k <= 6), 1'b1);
            check("sw_commit_low", clk_out, 1'b0);
            check("sw_low", lows >= 2, 1'b1);
        end
        exp_sel = s;
        sb_en   = 1'b1;
    endtask

    task automatic lose_lock(input logic [3:0] bad, input logic extra);
        pw_en = 1'b0;
        cyc(bad);
        bad_edge = ncyc;
        exp_err  = sat_inc(exp_err);
        check("pre_drop", locked, 1'b1);
        adv();
        check("lock_drop", locked, 1'b0);
        check("err_inc", err_cnt, exp_err);
        if (extra) begin
            cyc(4'h0);
            bad_edge = ncyc;
            adv();
            check("err_unlocked", err_cnt, exp_err);
        end
        wait_lock();
    endtask

    task automatic mid_switch(input logic [1:0] s, input logic [3:0] bad);
        int k;
        sb_en = 1'b0;
        pw_en = 1'b0;
        sel_if.sel       = s;
        sel_if.sel_valid = 1'b1;
        adv();
        check("ms_accept", acc_last, 1'b1);
        sel_if.sel_valid = 1'b0;
        cyc(bad);
        bad_edge = ncyc;
        exp_err  = sat_inc(exp_err);
        k = 0;
        while (!sel_if.sel_done && k < 10) begin
            adv();
            k++;
            check("ms_ready", sel_if.sel_ready, 1'b0);
        end
        check("ms_done", sel_if.sel_done, 1'b1);
        check("ms_cur", sel_if.cur_sel, s);
        check("ms_low", clk_out, 1'b0);
        check("ms_locked", locked, 1'b0);
        check("ms_err", err_cnt, exp_err);
        exp_sel = s;
        sb_en   = 1'b1;
        wait_lock();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        sel_if.sel       = 2'd0;
        sel_if.sel_valid = 1'b0;
        {ph270, ph180, ph90, ph0} = 4'h0;
        #3;
        do_reset();
        acquire();

        do_switch(2'd0);
        do_switch(2'd1);
        repeat (6) adv();
        do_switch(2'd0);
        do_switch(2'd2);
        repeat (6) adv();
        do_switch(2'd3);
        repeat (4) adv();

        lose_lock(4'hF, 1'b1);
        repeat (4) adv();
        mid_switch(2'd1, 4'h0);
        repeat (4) adv();
        mid_switch(2'd2, 4'hF);
        lose_lock(4'hF, 1'b0);
        lose_lock(4'hF, 1'b0);
        check("err_sat", err_cnt, ERR_MAX);
        repeat (4) adv();

        sel_if.sel       = 2'd3;
        sel_if.sel_valid = 1'b1;
        adv();
        check("rst_sw_accept", acc_last, 1'b1);
        do_reset();
        acquire();
        check("post_rst_cur", sel_if.cur_sel, RESET_SEL);
        do_switch(2'd1);
        repeat (6) adv();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_phase_select.md
# quad_phase_select

Glitch-free phase selector and quadrature monitor that consumes the four divide-by-4 quadrature phase signals (0°, 90°, 180°, 270°) produced in the `clk` domain. It checks that the phases follow the legal rotation and declares lock. It then forwards one selected phase as `clk_out`, switching phases on request without runt pulses. It sits directly downstream of the quadrature phase generator and feeds phase-aligned sampling logic.

## Interface

- `LOCK_CYCLES`, default 8: consecutive good samples required to assert `locked` (≥1).
- `ERR_W`, default 8: width of the lock-loss counter.
- `RESET_SEL`, default 2'd0: phase selected after reset.

- `clk` input 1: system clock; the phase inputs are synchronous to it.
- `rst` input 1: asynchronous, active-high reset.
- `ph0`, `ph90`, `ph180`, `ph270` input 1 each: quadrature phase signals, 4-cycle period.
- `sel` input 2: requested phase (0=0°, 1=90°, 2=180°, 3=270°).
- `sel_valid` input 1: request valid.
- `sel_ready` output 1: request may be accepted.
- `sel_done` output 1: one-cycle pulse when the new selection is committed.
- `cur_sel` output 2: currently committed phase.
- `clk_out` output 1: registered selected phase.
- `locked` output 1: quadrature pattern verified.
- `err_cnt` output ERR_W: saturating count of lock-loss events.

## Operation

- **Input stage.** `ph_q = {ph270,ph180,ph90,ph0}` is registered every cycle. `ph_prev` holds the previous `ph_q`.
- **Legal codes.** The legal codes are 4'hC, 4'h9, 4'h3 and 4'h6, in that order.
  - A sample is good when `ph_q` is a legal code and `ph_q == rotl(ph_prev, 1)`.
  - Every other sample is bad, including all-zero, all-one, reversed order and a stalled pattern.
- **Lock FSM, state UNLOCKED.**
  - `lock_cnt` increments on each good sample and clears on any bad sample.
  - When the LOCK_CYCLES-th consecutive good sample is registered, the FSM moves to LOCKED. `locked`=1 from that edge.
- **Lock FSM, state LOCKED.**
  - Any bad sample causes LOCKED→UNLOCKED: `locked`=0, `lock_cnt`=0, and `err_cnt` increments. `err_cnt` saturates at 2^ERR_W−1.
  - Bad samples while UNLOCKED do not increment `err_cnt`.
- **Select FSM, state IDLE.**
  - `sel_ready` = IDLE && `locked`. The handshake completes on `sel_valid && sel_ready`; `sel` is captured into `tgt`.
  - If `tgt == cur_sel`, the request commits immediately: `sel_done` pulses on the next cycle and there is no gating.
  - Otherwise the FSM goes to DRAIN.
- **Select FSM, state DRAIN.**
  - `clk_out` keeps following `ph_q[cur_sel]`.
  - When `ph_q[cur_sel]==0`, the gate is set and the FSM goes to ARM. `clk_out`=0 from the following edge.
- **Select FSM, state ARM.**
  - `clk_out` is held at 0.
  - When `ph_q[tgt]==0`: `cur_sel<=tgt`, `sel_done` pulses, and the FSM returns to IDLE. The gate clears and `clk_out` follows the new phase starting low.
- **Lock lost during DRAIN or ARM.** The FSM forces commit on the next edge: `cur_sel<=tgt`, `sel_done` pulses, and the state returns to IDLE. `clk_out` is 0 on that cycle.
- **Output register.** `clk_out <= gate ? 0 : ph_q[cur_sel]`.
- **Pulse widths.** Every high pulse on `clk_out` is 2 cycles and every low interval is ≥2 cycles, so no runt pulse is possible.

## Timing

- **Reset values.**
  - `clk_out`=0, `cur_sel`=RESET_SEL, `sel_ready`=0, `sel_done`=0, `locked`=0, `err_cnt`=0.
  - `ph_q`=0 and `ph_prev`=0, so the first comparison after reset is bad.
  - Select FSM=IDLE, lock FSM=UNLOCKED, gate=0.
- **Reset mid-switch.** The request is abandoned, `cur_sel` returns to RESET_SEL, and no `sel_done` is issued.
- **Latency.** `clk_out` equals the selected phase input delayed 2 cycles (input register plus output register).
- **Lock time.** With legal input from reset release, `locked` rises on the edge of good sample LOCK_CYCLES. With LOCK_CYCLES=8 that is edge 10 after reset release.
- **Switch duration.** Acceptance to `sel_done` takes ≤6 cycles.
  - Adjacent phase: 1–4 cycles to drain plus 1–2 cycles to arm.
  - Opposite phase: arm waits for the target's low half.
- **`sel_done`.** Exactly one cycle, coincident with the first cycle `cur_sel` shows the new value.
- **Back-to-back requests.** A new request can be accepted the cycle after `sel_done`.

## Test plan

1. **Lock acquisition.** Drive a legal rotation C→9→3→6 from reset with LOCK_CYCLES=8. Expect `locked`=1 at edge 10, `err_cnt`=0, and `clk_out` equal to `ph0` delayed 2 cycles.
2. **Adjacent switch.** Once locked, request `sel`=1. Expect a `sel_done` pulse, `cur_sel`=1, `clk_out` low for ≥2 cycles during the switch, and afterwards `clk_out` equal to `ph90` delayed 2.
3. **Opposite switch.** Request `sel`=2 from `cur_sel`=0. Expect no high pulse shorter than 2 cycles and no low gap shorter than 2 cycles, then `cur_sel`=2.
4. **Lock loss.** While locked, inject one sample of 4'hF.
   - Expect `locked`=0 on the next edge and `err_cnt`=1.
   - Expect relock after 8 good samples.
   - Expect no `err_cnt` change from bad samples while unlocked.
5. **Lock loss mid-switch.** Inject 4'h0 during ARM. Expect a forced `sel_done`, `cur_sel`=tgt, and `sel_ready`=0 until relock.
6. **Same-select request and saturation.**
   - Request `sel`=`cur_sel`: expect `sel_done` on the next cycle and no gap in `clk_out`.
   - With ERR_W=2, cause 5 lock losses: expect `err_cnt`=3.
